// File: rtl/risc8_boot_pkg.sv
// Shared constants and FSM encoding for the SPI-flash boot loader.
package risc8_boot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [7:0] FLASH_READ_OP = 8'h03;

endpackage

// File: rtl/risc8_spi_shift.sv
// SPI mode-0 byte engine: divider, SCK, shift registers and bit count.
// Handshake: a byte is accepted on any clk edge where i_start && o_ready.
// o_ready is high when idle and on the last clk of a byte's final high phase,
// so back-to-back starts produce a continuous SCK.
module risc8_spi_shift #(
  parameter int SPI_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_ready,
  input  logic       i_abort,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte
);

  localparam logic [7:0] DIV_RELOAD = 8'(SPI_DIV - 1);

  logic       r_busy;
  logic       r_sck;
  logic       r_mosi;
  logic       r_rx_valid;
  logic [7:0] r_div;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_bit;
  logic       w_last_cycle;

  assign w_last_cycle = r_busy && r_sck && (r_div == 8'd0) && (r_bit == 3'd7);
  assign o_ready      = !r_busy || w_last_cycle;
  assign o_sck        = r_sck;
  assign o_mosi       = r_mosi;
  assign o_rx_valid   = r_rx_valid;
  assign o_rx_byte    = r_rx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_div      <= 8'd0;
      r_tx       <= 8'd0;
      r_rx       <= 8'd0;
      r_bit      <= 3'd0;
    end else begin
      r_rx_valid <= 1'b0;
      if (i_abort) begin
        r_busy <= 1'b0;
        r_sck  <= 1'b0;
        r_mosi <= 1'b0;
      end else if (o_ready && i_start) begin
        // Loading always drops SCK, so the first bit gets a full low phase.
        r_busy <= 1'b1;
        r_sck  <= 1'b0;
        r_mosi <= i_tx_byte[7];
        r_tx   <= i_tx_byte;
        r_bit  <= 3'd0;
        r_div  <= DIV_RELOAD;
      end else if (r_busy) begin
        if (r_div != 8'd0) begin
          r_div <= r_div - 8'd1;
        end else begin
          r_div <= DIV_RELOAD;
          if (!r_sck) begin
            r_sck      <= 1'b1;
            r_rx       <= {r_rx[6:0], i_miso};
            r_rx_valid <= (r_bit == 3'd7);
          end else begin
            r_sck <= 1'b0;
            if (r_bit == 3'd7) begin
              r_busy <= 1'b0;
              r_mosi <= 1'b0;
            end else begin
              r_bit  <= r_bit + 3'd1;
              r_tx   <= {r_tx[6:0], 1'b0};
              r_mosi <= r_tx[6];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/risc8_boot_loader.sv
// Copies LOAD_LEN bytes from SPI flash into RAM while holding the CPU in reset,
// then hands the RAM port to the CPU.
module risc8_boot_loader
  import risc8_boot_pkg::*;
#(
  parameter logic [23:0] FLASH_ADDR = 24'h020000,
  parameter logic [15:0] RAM_BASE   = 16'h0000,
  parameter logic [16:0] LOAD_LEN   = 17'd65536,
  parameter int          SPI_DIV    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        ram_wen,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        cpu_reset,
  output logic        done,
  output state_t      dbg_state
);

  state_t      r_state;
  logic        r_cs_n;
  logic        r_ram_wen;
  logic [15:0] r_ram_addr;
  logic [7:0]  r_ram_wdata;
  logic [15:0] r_next_addr;
  logic [1:0]  r_cmd_idx;
  logic [16:0] r_req_cnt;
  logic [16:0] r_wr_cnt;
  logic        r_done;
  logic        r_cpu_reset;

  logic        w_start;
  logic        w_ready;
  logic [7:0]  w_tx_byte;
  logic        w_rx_valid;
  logic [7:0]  w_rx_byte;
  logic        w_data_valid;
  logic        w_last_write;
  logic        w_sck;
  logic        w_mosi;
  logic        w_fin;

  assign w_start = (r_state == CMD) || ((r_state == DATA) && (r_req_cnt != LOAD_LEN));

  always_comb begin
    w_tx_byte = 8'h00;
    if (r_state == CMD) begin
      case (r_cmd_idx)
        2'd0:    w_tx_byte = FLASH_READ_OP;
        2'd1:    w_tx_byte = FLASH_ADDR[23:16];
        2'd2:    w_tx_byte = FLASH_ADDR[15:8];
        default: w_tx_byte = FLASH_ADDR[7:0];
      endcase
    end
  end

  // The last command byte completes after DATA is entered; no data byte has
  // been requested yet at that point, which is how it is told apart.
  assign w_data_valid = w_rx_valid && (r_state == DATA) && (r_req_cnt != 17'd0);
  assign w_last_write = w_data_valid && (r_wr_cnt == LOAD_LEN - 17'd1);

  risc8_spi_shift #(.SPI_DIV(SPI_DIV)) u_spi (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_tx_byte  (w_tx_byte),
    .o_ready    (w_ready),
    .i_abort    (w_last_write),
    .i_miso     (spi_miso),
    .o_sck      (w_sck),
    .o_mosi     (w_mosi),
    .o_rx_valid (w_rx_valid),
    .o_rx_byte  (w_rx_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cs_n      <= 1'b1;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= RAM_BASE;
      r_ram_wdata <= 8'h00;
      r_next_addr <= RAM_BASE;
      r_cmd_idx   <= 2'd0;
      r_req_cnt   <= 17'd0;
      r_wr_cnt    <= 17'd0;
      r_done      <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_ram_wen <= 1'b0;
      case (r_state)
        IDLE: begin
          if (LOAD_LEN == 17'd0) begin
            r_state     <= FIN;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end else begin
            r_state <= CMD;
            r_cs_n  <= 1'b0;
          end
        end
        CMD: begin
          if (w_ready) begin
            if (r_cmd_idx == 2'd3) r_state <= DATA;
            else r_cmd_idx <= r_cmd_idx + 2'd1;
          end
        end
        DATA: begin
          if (w_ready && w_start) r_req_cnt <= r_req_cnt + 17'd1;
          if (w_data_valid) begin
            r_ram_wen   <= 1'b1;
            r_ram_addr  <= r_next_addr;
            r_ram_wdata <= w_rx_byte;
            r_next_addr <= r_next_addr + 16'd1;
            r_wr_cnt    <= r_wr_cnt + 17'd1;
            if (w_last_write) r_cs_n <= 1'b1;
          end
          // FIN follows one cycle after the final write so that pulse is not
          // masked by the CPU pass-through.
          if (r_wr_cnt == LOAD_LEN) begin
            r_state     <= FIN;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end
        end
        FIN:     r_state <= FIN;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_fin     = (r_state == FIN);
  assign spi_cs_n  = r_cs_n;
  assign spi_sck   = w_sck;
  assign spi_mosi  = w_mosi;
  assign ram_wen   = w_fin ? cpu_wen   : r_ram_wen;
  assign ram_addr  = w_fin ? cpu_addr  : r_ram_addr;
  assign ram_wdata = w_fin ? cpu_wdata : r_ram_wdata;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_risc8_boot_loader.sv
// Directed bench: three loader configurations, each with an SPI flash model.
module tb_risc8_boot_loader;
  import risc8_boot_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT A: LOAD_LEN=4, SPI_DIV=1, RAM_BASE=0000
  logic a_rst, a_cs_n, a_sck, a_mosi, a_miso, a_cpu_wen, a_ram_wen, a_cpu_reset, a_done;
  logic [15:0] a_cpu_addr, a_ram_addr;
  logic [7:0] a_cpu_wdata, a_ram_wdata;
  state_t a_state;
  // DUT B: LOAD_LEN=4, SPI_DIV=3, RAM_BASE=FFFE, FLASH_ADDR=123456
  logic b_rst, b_cs_n, b_sck, b_mosi, b_miso, b_cpu_wen, b_ram_wen, b_cpu_reset, b_done;
  logic [15:0] b_cpu_addr, b_ram_addr;
  logic [7:0] b_cpu_wdata, b_ram_wdata;
  state_t b_state;
  // DUT C: LOAD_LEN=0
  logic c_rst, c_cs_n, c_sck, c_mosi, c_miso, c_cpu_wen, c_ram_wen, c_cpu_reset, c_done;
  logic [15:0] c_cpu_addr, c_ram_addr;
  logic [7:0] c_cpu_wdata, c_ram_wdata;
  state_t c_state;

  risc8_boot_loader #(.LOAD_LEN(17'd4), .SPI_DIV(1)) dut_a (
    .clk(clk), .reset(a_rst), .spi_cs_n(a_cs_n), .spi_sck(a_sck), .spi_mosi(a_mosi),
    .spi_miso(a_miso), .cpu_wen(a_cpu_wen), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .ram_wen(a_ram_wen), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .cpu_reset(a_cpu_reset), .done(a_done), .dbg_state(a_state));

  risc8_boot_loader #(.FLASH_ADDR(24'h123456), .RAM_BASE(16'hFFFE), .LOAD_LEN(17'd4),
                      .SPI_DIV(3)) dut_b (
    .clk(clk), .reset(b_rst), .spi_cs_n(b_cs_n), .spi_sck(b_sck), .spi_mosi(b_mosi),
    .spi_miso(b_miso), .cpu_wen(b_cpu_wen), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .ram_wen(b_ram_wen), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .cpu_reset(b_cpu_reset), .done(b_done), .dbg_state(b_state));

  risc8_boot_loader #(.LOAD_LEN(17'd0), .SPI_DIV(2)) dut_c (
    .clk(clk), .reset(c_rst), .spi_cs_n(c_cs_n), .spi_sck(c_sck), .spi_mosi(c_mosi),
    .spi_miso(c_miso), .cpu_wen(c_cpu_wen), .cpu_addr(c_cpu_addr), .cpu_wdata(c_cpu_wdata),
    .ram_wen(c_ram_wen), .ram_addr(c_ram_addr), .ram_wdata(c_ram_wdata),
    .cpu_reset(c_cpu_reset), .done(c_done), .dbg_state(c_state));

  // Flash model and bus monitor state, index 0 = DUT A, 1 = DUT B
  logic [7:0]  flash [2][4];
  int          exp_div [2] = '{1, 3};
  int          cyc = 0;
  logic        prev_sck [2] = '{1'b0, 1'b0};
  logic        prev_mosi [2] = '{1'b0, 1'b0};
  logic        prev_cs [2] = '{1'b1, 1'b1};
  logic        miso_q [2] = '{1'b0, 1'b0};
  int          bit_cnt [2] = '{0, 0};
  logic [31:0] cmd_cap [2] = '{32'd0, 32'd0};
  int          cmd_n [2] = '{0, 0};
  int          rise_n [2] = '{0, 0};
  int          last_rise [2] = '{0, 0};
  int          mosi_bad [2] = '{0, 0};
  int          sck_cs_bad [2] = '{0, 0};
  int          ph_active [2] = '{0, 0};
  int          ph_len [2] = '{0, 0};
  int          ph_n [2] = '{0, 0};
  int          ph_bad [2] = '{0, 0};
  int          wr_n [2] = '{0, 0};
  logic [15:0] wr_addr [2][16];
  logic [7:0]  wr_data [2][16];
  int          lat_bad [2] = '{0, 0};
  int          viol [2] = '{0, 0};
  int          end_n [2] = '{0, 0};
  int          end_bad [2] = '{0, 0};
  int          c_cs_low = 0;
  logic [23:0] exp_q [$];

  task automatic mon_step(input int k, input logic cs, input logic s, input logic m,
                          input logic wen, input logic dn, input logic [15:0] addr,
                          input logic [7:0] wd);
    int j;
    if (cs) begin
      if (s) sck_cs_bad[k]++;
      if (!prev_cs[k]) begin
        end_n[k]++;
        if (!(wen && !s)) end_bad[k]++;
      end
      bit_cnt[k]   = 0;
      miso_q[k]    = 1'b0;
      ph_active[k] = 0;
    end else begin
      if (s && !prev_sck[k]) begin
        rise_n[k]++;
        last_rise[k] = cyc;
        if (m !== prev_mosi[k]) mosi_bad[k]++;
        if (bit_cnt[k] < 32) begin
          cmd_cap[k] = {cmd_cap[k][30:0], m};
          if (bit_cnt[k] == 31) cmd_n[k]++;
        end
        bit_cnt[k]++;
      end
      if (!s && prev_sck[k] && bit_cnt[k] >= 32) begin
        j = bit_cnt[k] - 32;
        miso_q[k] = flash[k][(j / 8) % 4][7 - (j % 8)];
      end
      if (s != prev_sck[k]) begin
        if (ph_active[k] != 0) begin
          ph_n[k]++;
          if (ph_len[k] != exp_div[k]) ph_bad[k]++;
        end
        ph_active[k] = 1;
        ph_len[k]    = 1;
      end else begin
        ph_len[k]++;
      end
    end
    if (wen && !dn) begin
      wr_addr[k][wr_n[k] % 16] = addr;
      wr_data[k][wr_n[k] % 16] = wd;
      if (cyc != last_rise[k] + 1) lat_bad[k]++;
      if (addr == 16'h1234) viol[k]++;
      wr_n[k]++;
    end
    prev_sck[k]  = s;
    prev_mosi[k] = m;
    prev_cs[k]   = cs;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon_step(0, a_cs_n, a_sck, a_mosi, a_ram_wen, a_done, a_ram_addr, a_ram_wdata);
    mon_step(1, b_cs_n, b_sck, b_mosi, b_ram_wen, b_done, b_ram_addr, b_ram_wdata);
    a_miso = miso_q[0];
    b_miso = miso_q[1];
    if (c_cs_n !== 1'b1) c_cs_low++;
  end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({a_cs_n, a_sck, a_mosi, a_ram_wen, a_cpu_reset, a_done} !== 6'b100010) begin
      bad++;
      $display("FAIL reset_a_ctrl got=%b want=100010",
               {a_cs_n, a_sck, a_mosi, a_ram_wen, a_cpu_reset, a_done});
    end
    total++;
    if ({a_ram_addr, a_ram_wdata} !== 24'h000000) begin
      bad++;
      $display("FAIL reset_a_ram got=%h want=000000", {a_ram_addr, a_ram_wdata});
    end
    total++;
    if ({b_ram_addr, b_ram_wdata} !== 24'hFFFE00) begin
      bad++;
      $display("FAIL reset_b_ram got=%h want=fffe00", {b_ram_addr, b_ram_wdata});
    end
  endtask

  task automatic test_zero_len;
    c_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({c_done, c_cpu_reset} !== 2'b10) begin
      bad++;
      $display("FAIL zero_len_done got=%b want=10", {c_done, c_cpu_reset});
    end
    repeat (5) @(negedge clk);
    total++;
    if (c_cs_low !== 0) begin
      bad++;
      $display("FAIL zero_len_cs got=%0d low-samples want=0", c_cs_low);
    end
    c_cpu_wdata = 8'hC3;
    #1;
    total++;
    if ({c_ram_wen, c_ram_addr, c_ram_wdata} !== {1'b1, 16'h00AA, 8'hC3}) begin
      bad++;
      $display("FAIL zero_len_pass got=%h want=100aac3", {c_ram_wen, c_ram_addr, c_ram_wdata});
    end
  endtask

  // Releases a_rst, waits for done, then checks the four writes and command.
  task automatic run_load_a(input string tag);
    int base, cbase, n;
    base  = wr_n[0];
    cbase = cmd_n[0];
    a_rst = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (a_done !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout done=%b want=1", tag, a_done);
    end
    exp_q.push_back({16'h0000, 8'hA5});
    exp_q.push_back({16'h0001, 8'h3C});
    exp_q.push_back({16'h0002, 8'h00});
    exp_q.push_back({16'h0003, 8'hFF});
    total++;
    if (wr_n[0] - base !== 4) begin
      bad++;
      $display("FAIL %s_wr_count got=%0d want=4", tag, wr_n[0] - base);
    end
    for (int i = 0; i < 4; i++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      total++;
      if ({wr_addr[0][(base + i) % 16], wr_data[0][(base + i) % 16]} !== e) begin
        bad++;
        $display("FAIL %s_wr%0d got=%h want=%h", tag, i,
                 {wr_addr[0][(base + i) % 16], wr_data[0][(base + i) % 16]}, e);
      end
    end
    total++;
    if (cmd_n[0] - cbase !== 1 || cmd_cap[0] !== 32'h03020000) begin
      bad++;
      $display("FAIL %s_cmd got=%h n=%0d want=03020000 n=1", tag, cmd_cap[0], cmd_n[0] - cbase);
    end
  endtask

  task automatic test_load_a;
    run_load_a("load_a");
    total++;
    if (rise_n[0] !== 64) begin
      bad++;
      $display("FAIL load_a_rises got=%0d want=64", rise_n[0]);
    end
    total++;
    if ({a_cpu_reset, a_cs_n, a_sck, a_mosi} !== 4'b0100) begin
      bad++;
      $display("FAIL load_a_fin got=%b want=0100", {a_cpu_reset, a_cs_n, a_sck, a_mosi});
    end
    total++;
    if (viol[0] !== 0) begin
      bad++;
      $display("FAIL cpu_ignored got=%0d cpu writes during load want=0", viol[0]);
    end
    total++;
    if ({a_ram_wen, a_ram_addr, a_ram_wdata} !== {1'b1, 16'h1234, 8'h77}) begin
      bad++;
      $display("FAIL cpu_pass got=%h want=1123477", {a_ram_wen, a_ram_addr, a_ram_wdata});
    end
    total++;
    if (lat_bad[0] !== 0 || mosi_bad[0] !== 0 || sck_cs_bad[0] !== 0) begin
      bad++;
      $display("FAIL load_a_timing got lat=%0d mosi=%0d sck_cs=%0d want all 0",
               lat_bad[0], mosi_bad[0], sck_cs_bad[0]);
    end
    total++;
    if (end_n[0] !== 1 || end_bad[0] !== 0) begin
      bad++;
      $display("FAIL load_a_end got n=%0d bad=%0d want n=1 bad=0", end_n[0], end_bad[0]);
    end
  endtask

  task automatic test_reset_mid;
    int base, n;
    #2 a_rst = 1'b1;
    #1;
    total++;
    if ({a_ram_wen, a_cpu_reset, a_done} !== 3'b010) begin
      bad++;
      $display("FAIL fin_reset got=%b want=010", {a_ram_wen, a_cpu_reset, a_done});
    end
    repeat (2) @(negedge clk);
    base  = wr_n[0];
    a_rst = 1'b0;
    n = 0;
    while (wr_n[0] == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (wr_n[0] - base !== 1) begin
      bad++;
      $display("FAIL mid_first_byte got=%0d writes want=1", wr_n[0] - base);
    end
    repeat (5) @(negedge clk);
    #2 a_rst = 1'b1;
    #1;
    total++;
    if ({a_cs_n, a_sck, a_mosi, a_ram_wen, a_cpu_reset, a_done} !== 6'b100010 ||
        {a_ram_addr, a_ram_wdata} !== 24'h000000 || a_state !== IDLE) begin
      bad++;
      $display("FAIL mid_reset got=%b %h st=%0d want=100010 000000 st=0",
               {a_cs_n, a_sck, a_mosi, a_ram_wen, a_cpu_reset, a_done},
               {a_ram_addr, a_ram_wdata}, a_state);
    end
    repeat (3) @(negedge clk);
    run_load_a("reload_a");
  endtask

  task automatic test_wrap_div3;
    int base, n;
    base  = wr_n[1];
    b_rst = 1'b0;
    n = 0;
    while (b_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (b_done !== 1'b1) begin
      bad++;
      $display("FAIL wrap_timeout done=%b want=1", b_done);
    end
    exp_q.push_back({16'hFFFE, 8'h11});
    exp_q.push_back({16'hFFFF, 8'h22});
    exp_q.push_back({16'h0000, 8'h33});
    exp_q.push_back({16'h0001, 8'h44});
    total++;
    if (wr_n[1] - base !== 4) begin
      bad++;
      $display("FAIL wrap_wr_count got=%0d want=4", wr_n[1] - base);
    end
    for (int i = 0; i < 4; i++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      total++;
      if ({wr_addr[1][(base + i) % 16], wr_data[1][(base + i) % 16]} !== e) begin
        bad++;
        $display("FAIL wrap_wr%0d got=%h want=%h", i,
                 {wr_addr[1][(base + i) % 16], wr_data[1][(base + i) % 16]}, e);
      end
    end
    total++;
    if (cmd_cap[1] !== 32'h03123456) begin
      bad++;
      $display("FAIL div3_cmd got=%h want=03123456", cmd_cap[1]);
    end
    total++;
    if (ph_n[1] !== 126 || ph_bad[1] !== 0) begin
      bad++;
      $display("FAIL div3_phases got n=%0d off=%0d want n=126 off=0", ph_n[1], ph_bad[1]);
    end
    total++;
    if (mosi_bad[1] !== 0 || lat_bad[1] !== 0 || end_bad[1] !== 0 || sck_cs_bad[1] !== 0) begin
      bad++;
      $display("FAIL div3_timing got mosi=%0d lat=%0d end=%0d sck_cs=%0d want all 0",
               mosi_bad[1], lat_bad[1], end_bad[1], sck_cs_bad[1]);
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_miso = 1'b0; b_miso = 1'b0; c_miso = 1'b0;
    a_cpu_wen = 1'b1; a_cpu_addr = 16'h1234; a_cpu_wdata = 8'h77;
    b_cpu_wen = 1'b0; b_cpu_addr = 16'h0000; b_cpu_wdata = 8'h00;
    c_cpu_wen = 1'b1; c_cpu_addr = 16'h00AA; c_cpu_wdata = 8'h5A;
    flash[0][0] = 8'hA5; flash[0][1] = 8'h3C; flash[0][2] = 8'h00; flash[0][3] = 8'hFF;
    flash[1][0] = 8'h11; flash[1][1] = 8'h22; flash[1][2] = 8'h33; flash[1][3] = 8'h44;
    test_reset();
    test_zero_len();
    test_load_a();
    test_reset_mid();
    test_wrap_div3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
